// File: rtl/axis_cic_decimator.sv
// -----------------------------------------------------------------------------
// axis_cic_decimator
//
// Purpose:
//    Receive-side decoder for a 1-bit sigma-delta bitstream. Each accepted bit
//    is mapped to +1 / -1. The result is filtered by an ORDER-stage CIC
//    decimator with ratio R = 2**DECIM_LOG2. The filter output is scaled and
//    saturated to WIDTH-bit signed PCM, then presented on an AXI-Stream master.
//
// Ports:
//    aclk                in   1      clock
//    arst                in   1      asynchronous reset, active-high
//                                    (asserted asynchronously, released on aclk)
//    s_axis_data_tdata   in   1      bitstream sample (1 -> +1, 0 -> -1)
//    s_axis_data_tvalid  in   1      input sample valid
//    s_axis_data_tready  out  1      block can accept an input sample
//    m_axis_data_tdata   out  WIDTH  decimated sample, signed
//    m_axis_data_tvalid  out  1      output sample valid
//    m_axis_data_tready  in   1      downstream accepts output
//
// Parameters:
//    WIDTH       output sample width
//    ORDER       number of integrator and comb stages (1..5)
//    DECIM_LOG2  log2 of the decimation ratio
// -----------------------------------------------------------------------------
module axis_cic_decimator #(
   parameter int WIDTH      = 16,
   parameter int ORDER      = 3,
   parameter int DECIM_LOG2 = 6
) (
   input  logic             aclk,
   input  logic             arst,
   input  logic             s_axis_data_tdata,
   input  logic             s_axis_data_tvalid,
   output logic             s_axis_data_tready,
   output logic [WIDTH-1:0] m_axis_data_tdata,
   output logic             m_axis_data_tvalid,
   input  logic             m_axis_data_tready
);

   // Bit growth of the CIC is ORDER*log2(R). Two extra bits hold the signed
   // full-scale value of +/-R**ORDER without ambiguity.
   localparam int GROWTH = ORDER * DECIM_LOG2;
   localparam int ACC_W  = GROWTH + 2;
   localparam int SHIFT  = GROWTH + 1 - WIDTH;

   localparam logic [DECIM_LOG2-1:0] PHASE_LAST = {DECIM_LOG2{1'b1}};

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   generate
      if (GROWTH + 1 < WIDTH) begin : gen_width_check
         $error("axis_cic_decimator: ORDER*DECIM_LOG2+1 must be >= WIDTH");
      end
      if (ORDER < 1 || ORDER > 5) begin : gen_order_check
         $error("axis_cic_decimator: ORDER must be in 1..5");
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Registers and wires
   // ---------------------------------------------------------------------------
   logic [DECIM_LOG2-1:0] r_phase;
   logic [ACC_W-1:0]      r_int [ORDER];
   logic [ACC_W-1:0]      r_dly [ORDER];
   logic [WIDTH-1:0]      r_tdata;
   logic                  r_tvalid;

   logic                  w_s_tready;
   logic                  w_s_hs;
   logic                  w_strobe;
   logic                  w_m_hs;
   logic [ACC_W-1:0]      w_x;
   logic [ACC_W-1:0]      w_comb_in [ORDER];
   logic [ACC_W-1:0]      w_comb_out;
   logic signed [ACC_W-1:0] w_scaled;
   logic [WIDTH-1:0]      w_sat;

   // ---------------------------------------------------------------------------
   // Handshakes
   // ---------------------------------------------------------------------------
   // Input stalls only when the sample about to be accepted would fire the
   // decimation strobe while the output register is still occupied and is
   // not being drained this cycle.
   assign w_s_tready = ~arst &
                       ~((r_phase == PHASE_LAST) & r_tvalid & ~m_axis_data_tready);
   assign w_s_hs     = s_axis_data_tvalid & w_s_tready;
   assign w_strobe   = w_s_hs & (r_phase == PHASE_LAST);
   assign w_m_hs     = r_tvalid & m_axis_data_tready;

   // Bit 1 maps to +1 and bit 0 maps to -1 (all ones in two's complement).
   assign w_x = s_axis_data_tdata ? ACC_W'(1) : {ACC_W{1'b1}};

   // ---------------------------------------------------------------------------
   // Phase counter: wraps naturally from R-1 to 0
   // ---------------------------------------------------------------------------
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         r_phase <= '0;
      end else if (w_s_hs) begin
         r_phase <= r_phase + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Integrator cascade. Each stage adds the previous stage's registered
   // value, so the cascade is pipelined by one sample per stage. Wrap-around
   // modulo 2**ACC_W is intended; the comb section cancels it.
   // ---------------------------------------------------------------------------
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         for (int k = 0; k < ORDER; k++) begin
            r_int[k] <= '0;
         end
      end else if (w_s_hs) begin
         r_int[0] <= r_int[0] + w_x;
         for (int k = 1; k < ORDER; k++) begin
            r_int[k] <= r_int[k] + r_int[k-1];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Comb section, combinational within the strobe cycle. The chain is
   // unrolled in one process so each stage sees the previous difference.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_comb_in  = '{default: '0};
      w_comb_out = r_int[ORDER-1];
      for (int k = 0; k < ORDER; k++) begin
         w_comb_in[k] = w_comb_out;
         w_comb_out   = w_comb_out - r_dly[k];
      end
   end

   // Each comb delay remembers its own input from the previous strobe.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         for (int k = 0; k < ORDER; k++) begin
            r_dly[k] <= '0;
         end
      end else if (w_strobe) begin
         for (int k = 0; k < ORDER; k++) begin
            r_dly[k] <= w_comb_in[k];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Scaling and saturation. Full scale +R**ORDER is exactly one LSB above
   // the positive limit after the shift, so it clips to the maximum code.
   // ---------------------------------------------------------------------------
   assign w_scaled = $signed(w_comb_out) >>> SHIFT;

   always_comb begin
      w_sat = w_scaled[WIDTH-1:0];
      if (w_scaled > SAT_MAX) begin
         w_sat = SAT_MAX[WIDTH-1:0];
      end else if (w_scaled < SAT_MIN) begin
         w_sat = SAT_MIN[WIDTH-1:0];
      end
   end

   // ---------------------------------------------------------------------------
   // Output register. A strobe takes priority over a drain, which covers a
   // strobe and an accept in the same cycle: the old sample leaves and the
   // new one loads with valid staying high.
   // ---------------------------------------------------------------------------
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
      end else if (w_strobe) begin
         r_tvalid <= 1'b1;
         r_tdata  <= w_sat;
      end else if (w_m_hs) begin
         r_tvalid <= 1'b0;
      end
   end

   assign s_axis_data_tready = w_s_tready;
   assign m_axis_data_tvalid = r_tvalid;
   assign m_axis_data_tdata  = r_tdata;

endmodule

// File: tb/tb_axis_cic_decimator.sv
// -----------------------------------------------------------------------------
// tb_axis_cic_decimator
//
// Purpose:
//    Self-checking bench for axis_cic_decimator with the default parameters
//    (WIDTH 16, ORDER 3, R 64). A behavioural model of the CIC equations
//    pushes the expected samples into a queue as inputs are accepted. Each
//    output handshake pops the queue and compares the two values. Each
//    scenario task also checks the settled values and the handshake timing
//    against fixed constants.
// -----------------------------------------------------------------------------
module tb_axis_cic_decimator;

   localparam int     R      = 64;
   localparam longint SAT_HI = 32767;
   localparam longint SAT_LO = -32768;

   logic        aclk     = 1'b0;
   logic        arst     = 1'b0;
   logic        s_tdata  = 1'b0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic [15:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b1;

   int n_run  = 0;
   int n_fail = 0;

   longint mdl_int [3];
   longint mdl_dly [3];
   int     mdl_phase;

   logic signed [15:0] exp_q [$];
   logic signed [15:0] got_q [$];

   axis_cic_decimator #(
      .WIDTH      (16),
      .ORDER      (3),
      .DECIM_LOG2 (6)
   ) dut (
      .aclk               (aclk),
      .arst               (arst),
      .s_axis_data_tdata  (s_tdata),
      .s_axis_data_tvalid (s_tvalid),
      .s_axis_data_tready (s_tready),
      .m_axis_data_tdata  (m_tdata),
      .m_axis_data_tvalid (m_tvalid),
      .m_axis_data_tready (m_tready)
   );

   always #5 aclk = ~aclk;

   // ---------------------------------------------------------------------------
   // Reference model of the CIC equations (20-bit modulo arithmetic)
   // ---------------------------------------------------------------------------
   function automatic longint wrap_acc(input longint v);
      longint t;
      t = v & ((64'sd1 << 20) - 1);
      if (t >= (64'sd1 << 19)) t = t - (64'sd1 << 20);
      return t;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 3; k++) begin
         mdl_int[k] = 0;
         mdl_dly[k] = 0;
      end
      mdl_phase = 0;
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic model_step(input logic b);
      longint c, t, y;
      if (mdl_phase == R - 1) begin
         c = mdl_int[2];
         for (int k = 0; k < 3; k++) begin
            t = wrap_acc(c - mdl_dly[k]);
            mdl_dly[k] = c;
            c = t;
         end
         y = c >>> 3;
         if (y > SAT_HI) y = SAT_HI;
         else if (y < SAT_LO) y = SAT_LO;
         exp_q.push_back(16'(y));
      end
      mdl_int[2] = wrap_acc(mdl_int[2] + mdl_int[1]);
      mdl_int[1] = wrap_acc(mdl_int[1] + mdl_int[0]);
      mdl_int[0] = wrap_acc(mdl_int[0] + (b ? 64'sd1 : -64'sd1));
      mdl_phase  = (mdl_phase + 1) % R;
   endtask

   // ---------------------------------------------------------------------------
   // One clock cycle: drive at the falling edge, sample 1 ns later (these are
   // the values the next rising edge sees), then advance to the next falling
   // edge. Output handshakes are scoreboarded here.
   // ---------------------------------------------------------------------------
   task automatic drive_cycle(input logic v, input logic b, output logic acc);
      logic signed [15:0] e;
      s_tvalid = v;
      s_tdata  = b;
      #1;
      acc = v & s_tready;
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
         n_run++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_extra: got %0d, no sample expected", $signed(m_tdata));
         end else begin
            e = exp_q.pop_front();
            if ($signed(m_tdata) !== e) begin
               n_fail++;
               $display("FAIL scoreboard: got %0d, expected %0d", $signed(m_tdata), e);
            end
         end
         got_q.push_back($signed(m_tdata));
      end
      if (acc) model_step(b);
      @(negedge aclk);
   endtask

   function automatic logic pattern_bit(input int kind, input int i);
      case (kind)
         0:       return 1'b1;
         1:       return 1'b0;
         2:       return (i % 2 == 0);
         default: return (i % 4 != 3);
      endcase
   endfunction

   task automatic feed_pattern(input int kind, input int count, input int drain);
      int   sent;
      int   guard;
      logic acc;
      sent  = 0;
      guard = 0;
      while (sent < count && guard < 4 * count + 100) begin
         drive_cycle(1'b1, pattern_bit(kind, sent), acc);
         if (acc) sent++;
         guard++;
      end
      if (sent < count) begin
         n_run++;
         n_fail++;
         $display("FAIL feed_timeout: accepted %0d, required %0d", sent, count);
      end
      for (int i = 0; i < drain; i++) drive_cycle(1'b0, 1'b0, acc);
   endtask

   task automatic do_reset();
      @(negedge aclk);
      arst     = 1'b1;
      s_tvalid = 1'b0;
      model_clear();
      repeat (2) @(negedge aclk);
      arst = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      #2 arst = 1'b1;
      #1;
      n_run++;
      if (m_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_tvalid: got %b, expected 0", m_tvalid);
      end
      n_run++;
      if (m_tdata !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_tdata: got %0d, expected 0", $signed(m_tdata));
      end
      model_clear();
      repeat (2) @(negedge aclk);
      arst = 1'b0;
      #1;
      n_run++;
      if (s_tready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_tready: got %b, expected 1", s_tready);
      end
      @(negedge aclk);
      $display("[TB] test_reset done");
   endtask

   // Constant ones over 128 frames. The integrators wrap many times, and
   // every settled output must stay at the positive clip value.
   task automatic test_const_one_wrap();
      do_reset();
      m_tready = 1'b1;
      feed_pattern(0, 128 * R, 4);
      n_run++;
      if (got_q.size() != 128) begin
         n_fail++;
         $display("FAIL ones_count: got %0d outputs, expected 128", got_q.size());
      end
      for (int i = 3; i < got_q.size(); i++) begin
         n_run++;
         if (got_q[i] !== 16'sd32767) begin
            n_fail++;
            $display("FAIL ones_value[%0d]: got %0d, expected 32767", i, got_q[i]);
         end
      end
      $display("[TB] test_const_one_wrap done, %0d outputs", got_q.size());
   endtask

   task automatic test_const_zero();
      do_reset();
      m_tready = 1'b1;
      feed_pattern(1, 10 * R, 4);
      n_run++;
      if (got_q.size() != 10) begin
         n_fail++;
         $display("FAIL zeros_count: got %0d outputs, expected 10", got_q.size());
      end
      for (int i = 3; i < got_q.size(); i++) begin
         n_run++;
         if (got_q[i] !== -16'sd32768) begin
            n_fail++;
            $display("FAIL zeros_value[%0d]: got %0d, expected -32768", i, got_q[i]);
         end
      end
      $display("[TB] test_const_zero done");
   endtask

   task automatic test_alternating();
      do_reset();
      m_tready = 1'b1;
      feed_pattern(2, 10 * R, 4);
      for (int i = 3; i < got_q.size(); i++) begin
         n_run++;
         if (got_q[i] !== 16'sd0) begin
            n_fail++;
            $display("FAIL alt_value[%0d]: got %0d, expected 0", i, got_q[i]);
         end
      end
      $display("[TB] test_alternating done");
   endtask

   task automatic test_duty_three_quarter();
      do_reset();
      m_tready = 1'b1;
      feed_pattern(3, 10 * R, 4);
      for (int i = 3; i < got_q.size(); i++) begin
         n_run++;
         if (got_q[i] < 16'sd16383 || got_q[i] > 16'sd16385) begin
            n_fail++;
            $display("FAIL duty_value[%0d]: got %0d, expected 16384 +/-1", i, got_q[i]);
         end
      end
      $display("[TB] test_duty_three_quarter done");
   endtask

   task automatic test_backpressure();
      int                 sent;
      int                 guard;
      int                 stalled;
      logic               acc;
      logic               b;
      logic signed [15:0] held;
      do_reset();
      m_tready = 1'b0;
      sent     = 0;
      guard    = 0;
      b        = 1'($urandom % 2);
      while (sent < R && guard < 1000) begin
         drive_cycle(1'b1, b, acc);
         if (acc) begin sent++; b = 1'($urandom % 2); end
         guard++;
      end
      n_run++;
      if (m_tvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_first_valid: got %b, expected 1", m_tvalid);
      end
      held = $signed(m_tdata);
      while (sent < 2 * R - 1 && guard < 2000) begin
         drive_cycle(1'b1, b, acc);
         if (acc) begin sent++; b = 1'($urandom % 2); end
         guard++;
      end
      n_run++;
      if (s_tready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_tready_low: got %b, expected 0", s_tready);
      end
      stalled = 0;
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b1, b, acc);
         if (acc) stalled++;
         n_run++;
         if ($signed(m_tdata) !== held) begin
            n_fail++;
            $display("FAIL bp_tdata_hold: got %0d, expected %0d", $signed(m_tdata), held);
         end
      end
      n_run++;
      if (stalled != 0) begin
         n_fail++;
         $display("FAIL bp_stall: got %0d accepts, expected 0", stalled);
      end
      m_tready = 1'b1;
      drive_cycle(1'b1, b, acc);
      n_run++;
      if (acc !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_resume: got accept %b, expected 1", acc);
      end
      if (acc) begin sent++; b = 1'($urandom % 2); end
      n_run++;
      if (m_tvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_valid_kept: got %b, expected 1", m_tvalid);
      end
      while (sent < 5 * R && guard < 4000) begin
         drive_cycle(1'b1, b, acc);
         if (acc) begin sent++; b = 1'($urandom % 2); end
         guard++;
      end
      for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, acc);
      n_run++;
      if (got_q.size() != 5 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL bp_count: got %0d outputs (%0d pending), expected 5 (0)",
                  got_q.size(), exp_q.size());
      end
      n_run++;
      if (got_q.size() == 0 || got_q[0] !== held) begin
         n_fail++;
         $display("FAIL bp_held_transfer: first output differs from held %0d", held);
      end
      $display("[TB] test_backpressure done");
   endtask

   task automatic test_reset_midframe();
      do_reset();
      m_tready = 1'b0;
      feed_pattern(0, R + 37, 0);
      n_run++;
      if (m_tvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pre_valid: got %b, expected 1", m_tvalid);
      end
      #2 arst = 1'b1;
      #1;
      n_run++;
      if (m_tvalid !== 1'b0 || m_tdata !== 16'd0) begin
         n_fail++;
         $display("FAIL mid_async_clear: got valid %b data %0d, expected 0 0",
                  m_tvalid, $signed(m_tdata));
      end
      model_clear();
      @(negedge aclk);
      @(negedge aclk);
      arst     = 1'b0;
      m_tready = 1'b1;
      feed_pattern(0, R - 1, 0);
      n_run++;
      if (m_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_early_valid: got %b after 63 inputs, expected 0", m_tvalid);
      end
      m_tready = 1'b0;
      feed_pattern(0, 1, 0);
      n_run++;
      if (m_tvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_first_valid: got %b after 64 inputs, expected 1", m_tvalid);
      end
      m_tready = 1'b1;
      feed_pattern(0, 0, 3);
      n_run++;
      if (got_q.size() != 1 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL mid_count: got %0d outputs (%0d pending), expected 1 (0)",
                  got_q.size(), exp_q.size());
      end
      $display("[TB] test_reset_midframe done");
   endtask

   initial begin
      test_reset();
      test_const_one_wrap();
      test_const_zero();
      test_alternating();
      test_duty_three_quarter();
      test_backpressure();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
